wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have port clk_sec, input, 1 bit: system clock (1 s period); one clock only.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port power, input, 1 bit: machine powered when 1.
REQ-004 SHALL have port start_pause, input, 1 bit: one-cycle start/pause/resume request, synchronous to clk_sec.
REQ-005 SHALL have port mode_sel, input, 3 bits: requested program.
REQ-006 SHALL have port water_level, input, 4 bits: requested water level.
REQ-007 SHALL have port model_now, output, 3 bits: latched program.
REQ-008 SHALL have port phase, output, 3 bits: current phase code.
REQ-009 SHALL have port time_now, output, 6 bits: seconds remaining in current phase.
REQ-010 SHALL have port time_all, output, 6 bits: seconds remaining in program.
REQ-011 SHALL have outputs water_in, water_out, motor, start_led, if_finish, each 1 bit, registered.

Function
REQ-012 SHALL implement states IDLE, FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN, PAUSE, DONE.
REQ-013 SHALL use phase durations FILL=WL, WASH=9, DRAIN=WL, RFILL=WL, RINSE=6, RDRAIN=WL, SPIN=3, where WL = water_level clamped to 1..10 (0->1, >10->10).
REQ-014 SHALL map programs: 000 wash+rinse+spin, 001 wash, 010 wash+rinse, 011 rinse, 100 rinse+spin, 101 spin; 110/111 treated as 000.
REQ-015 SHALL define stages: wash = FILL,WASH,DRAIN; rinse = RFILL,RINSE,RDRAIN; spin = SPIN.
REQ-016 SHALL, in IDLE with power=1 and start_pause=1, latch model_now and WL, and enter the program's first phase on that edge.
REQ-017 SHALL, at that edge, load time_now with the first phase duration and time_all with the sum of all the program's phase durations (max 58, fits 6 bits).
REQ-018 SHALL decrement time_now and time_all by 1 on each running edge.
REQ-019 SHALL advance to the next phase and load its duration on an edge where time_now==1, so a phase of duration d lasts exactly d cycles.
REQ-020 SHALL go to DONE after the last phase, with time_now=time_all=0.
REQ-021 SHALL drive water_in=1 in FILL/RFILL, water_out=1 in DRAIN/RDRAIN/SPIN, and motor=1 in WASH/RINSE/SPIN; all three SHALL be 0 elsewhere.
REQ-022 SHALL hold start_led=1 in all running phases and PAUSE.
REQ-023 SHALL, on start_pause while running, enter PAUSE, freeze both counters with no decrement that edge, and force water_in, water_out and motor to 0.
REQ-024 SHALL, on start_pause in PAUSE, resume the saved phase with counters unchanged.
REQ-025 SHALL hold if_finish=1 in DONE; start_pause in DONE SHALL return to IDLE.
REQ-026 SHALL, when power=0, go to IDLE on the next edge from any state with all outputs cleared; power=0 has priority over start_pause.
REQ-027 SHALL ignore mode_sel and water_level changes outside IDLE.

Reset
REQ-028 SHALL, on reset, asynchronously force IDLE, model_now=000, phase=IDLE code, time_now=0, time_all=0, and every 1-bit output 0.
REQ-029 SHALL, on reset mid-program, discard the program; a fresh start is required.

Configuration
REQ-030 SHALL, with DONE_BEEP_EN defined, add output buzzer, 1 bit, asserted for exactly 4 cycles on entry to DONE; the beep SHALL be cut short by start_pause or power=0.
REQ-031 SHALL, without DONE_BEEP_EN, have no buzzer port and no beep logic.

Structure
REQ-032 SHALL place the state/phase encoding, program codes, fixed durations (9, 6, 3) and WL clamp limits in shared package wash_pkg.
REQ-033 SHALL place the loadable down-counter (load, enable, value, is_one flag) in sub-module phase_timer; it is instantiated twice, once for time_now and once for time_all.

Verification
REQ-034 Bench SHALL cover: mode 000, WL=2, start -> time_all=26; phases FILL2, WASH9, DRAIN2, RFILL2, RINSE6, RDRAIN2, SPIN3; if_finish=1 after 26 cycles.
REQ-035 Bench SHALL cover: mode 001, WL=3 -> total 15; water_out=1 for exactly the 3 DRAIN cycles; then DONE.
REQ-036 Bench SHALL cover: mode 000, WL=2, pause at time_all=20, hold 5 cycles -> outputs 0, time_all stays 20; resume -> reaches 0 after 20 more cycles.
REQ-037 Bench SHALL cover: water_level=0 and water_level=15 with mode 000 -> time_all=22 and 58 respectively.
REQ-038 Bench SHALL cover: power=0 together with start_pause mid-WASH -> IDLE next edge with all outputs 0; async reset mid-RINSE -> immediate reset values.
REQ-039 Bench SHALL cover: with DONE_BEEP_EN, mode 101 -> buzzer high for 4 cycles starting at DONE entry.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared encodings, program codes, fixed phase durations and water-level
// limits for the wash sequencer, plus the program/phase decode helpers.
package wash_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FILL,
      ST_WASH,
      ST_DRAIN,
      ST_RFILL,
      ST_RINSE,
      ST_RDRAIN,
      ST_SPIN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [2:0] PH_IDLE   = 3'd0;
   localparam logic [2:0] PH_FILL   = 3'd1;
   localparam logic [2:0] PH_WASH   = 3'd2;
   localparam logic [2:0] PH_DRAIN  = 3'd3;
   localparam logic [2:0] PH_RFILL  = 3'd4;
   localparam logic [2:0] PH_RINSE  = 3'd5;
   localparam logic [2:0] PH_RDRAIN = 3'd6;
   localparam logic [2:0] PH_SPIN   = 3'd7;

   localparam logic [2:0] PRG_FULL       = 3'b000;
   localparam logic [2:0] PRG_WASH       = 3'b001;
   localparam logic [2:0] PRG_WASH_RINSE = 3'b010;
   localparam logic [2:0] PRG_RINSE      = 3'b011;
   localparam logic [2:0] PRG_RINSE_SPIN = 3'b100;
   localparam logic [2:0] PRG_SPIN       = 3'b101;

   localparam logic [5:0] DUR_WASH  = 6'd9;
   localparam logic [5:0] DUR_RINSE = 6'd6;
   localparam logic [5:0] DUR_SPIN  = 6'd3;

   localparam logic [3:0] WL_MIN = 4'd1;
   localparam logic [3:0] WL_MAX = 4'd10;

   function automatic logic [3:0] wl_clamp(input logic [3:0] wl);
      if (wl < WL_MIN) return WL_MIN;
      if (wl > WL_MAX) return WL_MAX;
      return wl;
   endfunction

   // Unlisted codes (110/111) fall into the defaults and behave as PRG_FULL.
   function automatic logic has_wash(input logic [2:0] mode);
      case (mode)
         PRG_RINSE, PRG_RINSE_SPIN, PRG_SPIN: return 1'b0;
         default:                             return 1'b1;
      endcase
   endfunction

   function automatic logic has_rinse(input logic [2:0] mode);
      case (mode)
         PRG_WASH, PRG_SPIN: return 1'b0;
         default:            return 1'b1;
      endcase
   endfunction

   function automatic logic has_spin(input logic [2:0] mode);
      case (mode)
         PRG_WASH, PRG_WASH_RINSE, PRG_RINSE: return 1'b0;
         default:                             return 1'b1;
      endcase
   endfunction

   function automatic state_t first_phase(input logic [2:0] mode);
      if (has_wash(mode))  return ST_FILL;
      if (has_rinse(mode)) return ST_RFILL;
      return ST_SPIN;
   endfunction

   function automatic state_t next_phase(input logic [2:0] mode, input state_t st);
      case (st)
         ST_FILL:   return ST_WASH;
         ST_WASH:   return ST_DRAIN;
         ST_DRAIN:  return has_rinse(mode) ? ST_RFILL : (has_spin(mode) ? ST_SPIN : ST_DONE);
         ST_RFILL:  return ST_RINSE;
         ST_RINSE:  return ST_RDRAIN;
         ST_RDRAIN: return has_spin(mode) ? ST_SPIN : ST_DONE;
         default:   return ST_DONE;
      endcase
   endfunction

   function automatic logic [5:0] phase_dur(input state_t st, input logic [3:0] wl);
      case (st)
         ST_FILL, ST_DRAIN, ST_RFILL, ST_RDRAIN: return {2'b00, wl};
         ST_WASH:  return DUR_WASH;
         ST_RINSE: return DUR_RINSE;
         ST_SPIN:  return DUR_SPIN;
         default:  return 6'd0;
      endcase
   endfunction

   function automatic logic [5:0] prog_total(input logic [2:0] mode, input logic [3:0] wl);
      logic [5:0] w;
      logic [5:0] t;
      w = {2'b00, wl};
      t = 6'd0;
      if (has_wash(mode))  t = t + w + w + DUR_WASH;
      if (has_rinse(mode)) t = t + w + w + DUR_RINSE;
      if (has_spin(mode))  t = t + DUR_SPIN;
      return t;
   endfunction

   function automatic logic [2:0] phase_code(input state_t st);
      case (st)
         ST_FILL:   return PH_FILL;
         ST_WASH:   return PH_WASH;
         ST_DRAIN:  return PH_DRAIN;
         ST_RFILL:  return PH_RFILL;
         ST_RINSE:  return PH_RINSE;
         ST_RDRAIN: return PH_RDRAIN;
         ST_SPIN:   return PH_SPIN;
         default:   return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 6-bit down-counter; load wins over enable and the count stops at 0.
module phase_timer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [5:0] i_load_val,
   input  logic       i_en,
   output logic [5:0] o_value,
   output logic       o_is_one
);

   logic [5:0] r_value;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_value <= 6'd0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_en && (r_value != 6'd0)) begin
         r_value <= r_value - 6'd1;
      end
   end

   assign o_value  = r_value;
   assign o_is_one = (r_value == 6'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer with pause/resume and power-off abort.
// Optional DONE_BEEP_EN adds a 4-cycle buzzer pulse on entry to DONE.
//
// state    | meaning
// ST_IDLE  | waiting for start, nothing driven
// ST_FILL  | wash fill, water_in on
// ST_WASH  | wash agitate, motor on
// ST_DRAIN | wash drain, water_out on
// ST_RFILL | rinse fill, water_in on
// ST_RINSE | rinse agitate, motor on
// ST_RDRAIN| rinse drain, water_out on
// ST_SPIN  | spin, motor and water_out on
// ST_PAUSE | counters frozen, r_saved holds the phase to resume
// ST_DONE  | program complete, if_finish on
module wash_sequencer
   import wash_pkg::*;
(
   input  logic       clk_sec,
   input  logic       reset,
   input  logic       power,
   input  logic       start_pause,
   input  logic [2:0] mode_sel,
   input  logic [3:0] water_level,
   output logic [2:0] model_now,
   output logic [2:0] phase,
   output logic [5:0] time_now,
   output logic [5:0] time_all,
   output logic       water_in,
   output logic       water_out,
   output logic       motor,
   output logic       start_led,
   output logic       if_finish
`ifdef DONE_BEEP_EN
   ,
   output logic       buzzer
`endif
);

   state_t     r_state, r_saved;
   logic [2:0] r_mode, r_phase;
   logic [3:0] r_wl;
   logic       r_water_in, r_water_out, r_motor, r_start_led, r_if_finish;

   state_t     w_state_nxt, w_saved_nxt, w_adv;
   logic [2:0] w_mode_nxt, w_phase_nxt;
   logic [3:0] w_wl_nxt, w_wl_in;
   logic       w_now_load, w_now_en, w_all_load, w_all_en;
   logic [5:0] w_now_val, w_all_val;
   logic       w_now_is_one, w_all_is_one;
   logic       w_water_in_nxt, w_water_out_nxt, w_motor_nxt, w_led_nxt, w_fin_nxt;

   assign w_wl_in = wl_clamp(water_level);

   phase_timer u_time_now (
      .i_clk      (clk_sec),
      .i_rst      (reset),
      .i_load     (w_now_load),
      .i_load_val (w_now_val),
      .i_en       (w_now_en),
      .o_value    (time_now),
      .o_is_one   (w_now_is_one)
   );

   phase_timer u_time_all (
      .i_clk      (clk_sec),
      .i_rst      (reset),
      .i_load     (w_all_load),
      .i_load_val (w_all_val),
      .i_en       (w_all_en),
      .o_value    (time_all),
      .o_is_one   (w_all_is_one)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_saved_nxt = r_saved;
      w_mode_nxt  = r_mode;
      w_wl_nxt    = r_wl;
      w_now_load  = 1'b0;
      w_now_val   = 6'd0;
      w_now_en    = 1'b0;
      w_all_load  = 1'b0;
      w_all_val   = 6'd0;
      w_all_en    = 1'b0;
      // The program total reaching its last second is the end of the program.
      w_adv       = w_all_is_one ? ST_DONE : next_phase(r_mode, r_state);

      if (!power) begin
         w_state_nxt = ST_IDLE;
         w_mode_nxt  = 3'd0;
         w_now_load  = 1'b1;
         w_all_load  = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_pause) begin
                  w_mode_nxt  = mode_sel;
                  w_wl_nxt    = w_wl_in;
                  w_state_nxt = first_phase(mode_sel);
                  w_now_load  = 1'b1;
                  w_now_val   = phase_dur(first_phase(mode_sel), w_wl_in);
                  w_all_load  = 1'b1;
                  w_all_val   = prog_total(mode_sel, w_wl_in);
               end
            end
            ST_PAUSE: begin
               if (start_pause) w_state_nxt = r_saved;
            end
            ST_DONE: begin
               if (start_pause) w_state_nxt = ST_IDLE;
            end
            default: begin
               if (start_pause) begin
                  w_saved_nxt = r_state;
                  w_state_nxt = ST_PAUSE;
               end else begin
                  w_all_en = 1'b1;
                  if (w_now_is_one) begin
                     w_state_nxt = w_adv;
                     w_now_load  = 1'b1;
                     w_now_val   = phase_dur(w_adv, r_wl);
                  end else begin
                     w_now_en = 1'b1;
                  end
               end
            end
         endcase
      end

      w_phase_nxt     = phase_code((w_state_nxt == ST_PAUSE) ? w_saved_nxt : w_state_nxt);
      w_water_in_nxt  = (w_state_nxt inside {ST_FILL, ST_RFILL});
      w_water_out_nxt = (w_state_nxt inside {ST_DRAIN, ST_RDRAIN, ST_SPIN});
      w_motor_nxt     = (w_state_nxt inside {ST_WASH, ST_RINSE, ST_SPIN});
      w_led_nxt       = !(w_state_nxt inside {ST_IDLE, ST_DONE});
      w_fin_nxt       = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk_sec or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_saved     <= ST_IDLE;
         r_mode      <= 3'd0;
         r_wl        <= WL_MIN;
         r_phase     <= PH_IDLE;
         r_water_in  <= 1'b0;
         r_water_out <= 1'b0;
         r_motor     <= 1'b0;
         r_start_led <= 1'b0;
         r_if_finish <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_saved     <= w_saved_nxt;
         r_mode      <= w_mode_nxt;
         r_wl        <= w_wl_nxt;
         r_phase     <= w_phase_nxt;
         r_water_in  <= w_water_in_nxt;
         r_water_out <= w_water_out_nxt;
         r_motor     <= w_motor_nxt;
         r_start_led <= w_led_nxt;
         r_if_finish <= w_fin_nxt;
      end
   end

   assign model_now = r_mode;
   assign phase     = r_phase;
   assign water_in  = r_water_in;
   assign water_out = r_water_out;
   assign motor     = r_motor;
   assign start_led = r_start_led;
   assign if_finish = r_if_finish;

`ifdef DONE_BEEP_EN
   logic [1:0] r_beep_cnt;
   logic       r_buzzer;

   // Leaving DONE (start_pause or power loss) cuts the beep immediately.
   always_ff @(posedge clk_sec or posedge reset) begin
      if (reset) begin
         r_buzzer   <= 1'b0;
         r_beep_cnt <= 2'd0;
      end else if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
         r_buzzer   <= 1'b1;
         r_beep_cnt <= 2'd3;
      end else if ((w_state_nxt == ST_DONE) && (r_beep_cnt != 2'd0)) begin
         r_buzzer   <= 1'b1;
         r_beep_cnt <= r_beep_cnt - 2'd1;
      end else begin
         r_buzzer   <= 1'b0;
         r_beep_cnt <= 2'd0;
      end
   end

   assign buzzer = r_buzzer;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: per-second scoreboard against a schedule model.
module tb_wash_sequencer;

   logic       clk_sec = 1'b0;
   logic       reset, power, start_pause;
   logic [2:0] mode_sel;
   logic [3:0] water_level;
   logic [2:0] model_now, phase;
   logic [5:0] time_now, time_all;
   logic       water_in, water_out, motor, start_led, if_finish;
`ifdef DONE_BEEP_EN
   logic       buzzer;
`endif

   wash_sequencer dut (
      .clk_sec     (clk_sec),
      .reset       (reset),
      .power       (power),
      .start_pause (start_pause),
      .mode_sel    (mode_sel),
      .water_level (water_level),
      .model_now   (model_now),
      .phase       (phase),
      .time_now    (time_now),
      .time_all    (time_all),
      .water_in    (water_in),
      .water_out   (water_out),
      .motor       (motor),
      .start_led   (start_led),
      .if_finish   (if_finish)
`ifdef DONE_BEEP_EN
      ,
      .buzzer      (buzzer)
`endif
   );

   always #5 clk_sec = ~clk_sec;

   typedef struct {
      string       tag;
      logic [23:0] vec;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_bad = 0;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int         m_st = M_IDLE;
   int         m_age = 0;
   logic [2:0] m_mode = 3'd0;
   logic [2:0] m_sched[$];

   function automatic logic [23:0] dut_vec();
      logic b;
      b = 1'b0;
`ifdef DONE_BEEP_EN
      b = buzzer;
`endif
      return {model_now, phase, time_now, time_all,
              water_in, water_out, motor, start_led, if_finish, b};
   endfunction

   function automatic logic [23:0] model_vec();
      logic [2:0] ph;
      int         tn, ta;
      logic       run, wi, wo, mo, led, fin, bz;
      ph = 3'd0; tn = 0; ta = 0;
      if (m_st == M_RUN || m_st == M_PAUSE) begin
         ph = m_sched[0];
         ta = m_sched.size();
         tn = 1;
         while (tn < ta && m_sched[tn] == ph) tn++;
      end
      run = (m_st == M_RUN);
      wi  = run && (ph == 3'd1 || ph == 3'd4);
      wo  = run && (ph == 3'd3 || ph == 3'd6 || ph == 3'd7);
      mo  = run && (ph == 3'd2 || ph == 3'd5 || ph == 3'd7);
      led = run || (m_st == M_PAUSE);
      fin = (m_st == M_DONE);
      bz  = 1'b0;
`ifdef DONE_BEEP_EN
      bz  = fin && (m_age < 4);
`endif
      return {m_mode, ph, 6'(tn), 6'(ta), wi, wo, mo, led, fin, bz};
   endfunction

   task automatic push_n(input logic [2:0] code, input int n);
      for (int i = 0; i < n; i++) m_sched.push_back(code);
   endtask

   task automatic build(input logic [2:0] m, input logic [3:0] wl);
      int w;
      w = (wl == 0) ? 1 : ((wl > 10) ? 10 : int'(wl));
      m_sched.delete();
      if (!(m == 3 || m == 4 || m == 5)) begin
         push_n(3'd1, w); push_n(3'd2, 9); push_n(3'd3, w);
      end
      if (!(m == 1 || m == 5)) begin
         push_n(3'd4, w); push_n(3'd5, 6); push_n(3'd6, w);
      end
      if (!(m == 1 || m == 2 || m == 3)) push_n(3'd7, 3);
   endtask

   task automatic model_edge(input logic p, input logic sp);
      if (!p) begin
         m_st = M_IDLE; m_mode = 3'd0; m_sched.delete();
      end else begin
         case (m_st)
            M_IDLE: if (sp) begin
               m_mode = mode_sel; build(mode_sel, water_level); m_st = M_RUN;
            end
            M_RUN: if (sp) m_st = M_PAUSE;
                   else begin
                      void'(m_sched.pop_front());
                      if (m_sched.size() == 0) begin m_st = M_DONE; m_age = 0; end
                   end
            M_PAUSE: if (sp) m_st = M_RUN;
            default: if (sp) m_st = M_IDLE; else m_age++;
         endcase
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_mode = 3'd0; m_sched.delete();
   endtask

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic p, input logic sp, input string tag);
      exp_t e;
      power = p;
      start_pause = sp;
      model_edge(p, sp);
      e.tag = tag;
      e.vec = model_vec();
      sb.push_back(e);
      @(posedge clk_sec);
      #1;
      start_pause = 1'b0;
      e = sb.pop_front();
      n_vec++;
      assert (dut_vec() === e.vec) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", e.tag, dut_vec(), e.vec);
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wo_cnt;
      int len;
      reset = 1'b1; power = 1'b0; start_pause = 1'b0;
      mode_sel = 3'd0; water_level = 4'd0;
      #1;
      chk("reset_vals", dut_vec(), 24'h0);
      @(posedge clk_sec); #1;
      reset = 1'b0;
      step(1'b1, 1'b0, "idle");

      // full program, WL=2, with input changes while running
      mode_sel = 3'b000; water_level = 4'd2;
      step(1'b1, 1'b1, "s1_start");
      chk("s1_total", 24'(time_all), 24'd26);
      chk("s1_first", {18'd0, phase, 3'd0} | 24'(time_now), {18'd0, 3'd1, 3'd0} | 24'd2);
      mode_sel = 3'b101; water_level = 4'd15;
      run(25, "s1_run");
      chk("s1_not_yet", 24'(if_finish), 24'd0);
      step(1'b1, 1'b0, "s1_last");
      chk("s1_finish", {23'd0, if_finish} | {12'd0, time_all, time_now}, 24'd1);
      run(5, "s1_done");
      step(1'b1, 1'b1, "s1_ack");

      // wash only, WL=3
      mode_sel = 3'b001; water_level = 4'd3;
      step(1'b1, 1'b1, "s2_start");
      chk("s2_total", 24'(time_all), 24'd15);
      wo_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (water_out) wo_cnt++;
         step(1'b1, 1'b0, "s2_run");
      end
      chk("s2_drain_cycles", 24'(wo_cnt), 24'd3);
      chk("s2_finish", 24'(if_finish), 24'd1);
      step(1'b1, 1'b1, "s2_ack");

      // pause and resume
      mode_sel = 3'b000; water_level = 4'd2;
      step(1'b1, 1'b1, "s3_start");
      run(6, "s3_run");
      chk("s3_at20", 24'(time_all), 24'd20);
      step(1'b1, 1'b1, "s3_pause");
      run(5, "s3_hold");
      chk("s3_frozen", 24'(time_all), 24'd20);
      chk("s3_outs_off", {21'd0, water_in, water_out, motor}, 24'd0);
      step(1'b1, 1'b1, "s3_resume");
      chk("s3_resumed", 24'(time_all), 24'd20);
      run(20, "s3_run2");
      chk("s3_end", {17'd0, time_all, if_finish}, 24'd1);
      step(1'b1, 1'b1, "s3_ack");

      // water level clamp limits
      water_level = 4'd0;
      step(1'b1, 1'b1, "s4_wl0_start");
      chk("s4_wl0_total", 24'(time_all), 24'd22);
      run(22, "s4_wl0_run");
      step(1'b1, 1'b1, "s4_wl0_ack");
      water_level = 4'd15;
      step(1'b1, 1'b1, "s4_wl15_start");
      chk("s4_wl15_total", 24'(time_all), 24'd58);
      run(58, "s4_wl15_run");
      step(1'b1, 1'b1, "s4_wl15_ack");

      // remaining program codes at WL=1
      water_level = 4'd1;
      for (int m = 2; m < 8; m++) begin
         if (m == 5) continue;
         mode_sel = 3'(m);
         step(1'b1, 1'b1, "s5_start");
         len = m_sched.size();
         run(len, "s5_run");
         step(1'b1, 1'b1, "s5_ack");
      end

      // power loss together with start_pause mid-WASH
      mode_sel = 3'b000; water_level = 4'd2;
      step(1'b1, 1'b1, "s6_start");
      run(3, "s6_run");
      chk("s6_in_wash", 24'(phase), 24'd2);
      step(1'b0, 1'b1, "s6_pwroff");
      chk("s6_all_zero", dut_vec(), 24'h0);
      step(1'b0, 1'b0, "s6_off");
      step(1'b1, 1'b0, "s6_on");

      // asynchronous reset mid-RINSE
      step(1'b1, 1'b1, "s7_start");
      run(16, "s7_run");
      chk("s7_in_rinse", 24'(phase), 24'd5);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("s7_async_reset", dut_vec(), 24'h0);
      @(posedge clk_sec); #1;
      reset = 1'b0;
      step(1'b1, 1'b0, "s7_after");

      // spin only, DONE beep, then beep cut short
      mode_sel = 3'b101;
      step(1'b1, 1'b1, "s8_start");
      chk("s8_total", 24'(time_all), 24'd3);
      run(3, "s8_run");
`ifdef DONE_BEEP_EN
      chk("s8_beep0", 24'(buzzer), 24'd1);
      for (int i = 1; i < 6; i++) begin
         step(1'b1, 1'b0, "s8_done");
         chk("s8_beep", 24'(buzzer), (i < 4) ? 24'd1 : 24'd0);
      end
`else
      chk("s8_finish", 24'(if_finish), 24'd1);
      run(5, "s8_done");
`endif
      step(1'b1, 1'b1, "s8_ack");
      step(1'b1, 1'b1, "s9_start");
      run(3, "s9_run");
      step(1'b1, 1'b0, "s9_done");
      step(1'b1, 1'b1, "s9_cut");
      step(1'b1, 1'b0, "s9_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
